mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single main-memory port between two caching systems: requester 0 (instruction side) and requester 1 (data side). It grants one transaction at a time using round-robin priority and latches the granted request's operation, address and write data. It drives the memory read/write strobe until memory answers, then returns a one-cycle completion pulse with the registered block data. It sits between the cache FSMs' main_read/main_write outputs and the Main_Memory instance.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/rr_pick2.sv | 19 +
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port main-memory arbiter.
//   - arb_state_e : controller state encoding (IDLE / BUSY / RESP)
//   - OP_READ / OP_WRITE : encoding of the latched operation
//   - DEF_* : default bus widths used by the interface and the top
package mem_arb_pkg;

   localparam int DEF_ADDR_WIDTH  = 10;
   localparam int DEF_WIDTH       = 32;
   localparam int DEF_BLOCK_WIDTH = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around the arbiter: the two
// requester ports (read/write request, address, write data, done), the
// shared read block, the main-memory port, and the grant/busy status.
//   modport slave  : the arbiter's view (requests and memory answer in)
//   modport master : the environment's view (requesters + memory)
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
);

   logic                   req0_read;
   logic                   req0_write;
   logic [ADDR_WIDTH-1:0]  req0_addr;
   logic [WIDTH-1:0]       req0_wdata;
   logic                   req0_done;

   logic                   req1_read;
   logic                   req1_write;
   logic [ADDR_WIDTH-1:0]  req1_addr;
   logic [WIDTH-1:0]       req1_wdata;
   logic                   req1_done;

   logic [BLOCK_WIDTH-1:0] rdata;

   logic                   mem_read;
   logic                   mem_write;
   logic [ADDR_WIDTH-1:0]  mem_address;
   logic [WIDTH-1:0]       mem_write_data;
   logic                   mem_ready;
   logic [BLOCK_WIDTH-1:0] mem_read_data;

   logic [1:0]             grant;
   logic                   busy;

   modport slave (
      input  req0_read, req0_write, req0_addr, req0_wdata,
      input  req1_read, req1_write, req1_addr, req1_wdata,
      input  mem_ready, mem_read_data,
      output req0_done, req1_done, rdata,
      output mem_read, mem_write, mem_address, mem_write_data,
      output grant, busy
   );

   modport master (
      output req0_read, req0_write, req0_addr, req0_wdata,
      output req1_read, req1_write, req1_addr, req1_wdata,
      output mem_ready, mem_read_data,
      input  req0_done, req1_done, rdata,
      input  mem_read, mem_write, mem_address, mem_write_data,
      input  grant, busy
   );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector.
//   pending_i    : [1:0] requester N has a request pending
//   last_grant_i : index of the requester granted most recently
//   pick_o       : [1:0] one-hot winner, 00 when nothing is pending
module rr_pick2 (
   input  logic [1:0] pending_i,
   input  logic       last_grant_i,
   output logic [1:0] pick_o
);

   always_comb begin
      pick_o = pending_i;
      // On a tie the requester that did not win last time goes first.
      if (pending_i == 2'b11) begin
         pick_o = last_grant_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between requester 0 (instruction
// side) and requester 1 (data side). One transaction at a time, round-robin
// on ties. The granted request is latched, the strobe is held until memory
// answers, then the owner receives a one-cycle done with the captured block.
//   clk   : system clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : requester ports, memory port, rdata, grant and busy (slave view)
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
   input logic             clk,
   input logic             reset,
   mem_port_arbiter_if.slave bus
);

   arb_state_e             state_q, state_d;
   logic [1:0]             owner_q, owner_d;
   logic                   op_q, op_d;
   logic                   last_q, last_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0]       wdata_q, wdata_d;
   logic [BLOCK_WIDTH-1:0] rdata_q, rdata_d;

   logic [1:0] pending;
   logic [1:0] pick;

   assign pending = {bus.req1_read | bus.req1_write,
                     bus.req0_read | bus.req0_write};

   rr_pick2 u_pick (
      .pending_i    (pending),
      .last_grant_i (last_q),
      .pick_o       (pick)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      op_d    = op_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (pick != 2'b00) begin
               state_d = BUSY;
               owner_d = pick;
               // Read and write together is treated as a write.
               if (pick[0]) begin
                  op_d    = bus.req0_write ? OP_WRITE : OP_READ;
                  addr_d  = bus.req0_addr;
                  wdata_d = bus.req0_wdata;
                  last_d  = 1'b0;
               end else begin
                  op_d    = bus.req1_write ? OP_WRITE : OP_READ;
                  addr_d  = bus.req1_addr;
                  wdata_d = bus.req1_wdata;
                  last_d  = 1'b1;
               end
            end
         end
         BUSY: begin
            // The block is captured for writes too; its value is then unused.
            if (bus.mem_ready) begin
               rdata_d = bus.mem_read_data;
               state_d = RESP;
            end
         end
         RESP: begin
            // No arbitration here, so a finishing request is never re-granted.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 2'b00;
         op_q    <= OP_READ;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decode registers only; owner_q is left stale in IDLE, so
   // everything owner-related is qualified by the state.
   assign bus.grant          = (state_q != IDLE) ? owner_q : 2'b00;
   assign bus.busy           = (state_q != IDLE);
   assign bus.mem_read       = (state_q == BUSY) && (op_q == OP_READ);
   assign bus.mem_write      = (state_q == BUSY) && (op_q == OP_WRITE);
   assign bus.req0_done      = (state_q == RESP) && owner_q[0];
   assign bus.req1_done      = (state_q == RESP) && owner_q[1];
   assign bus.rdata          = rdata_q;
   assign bus.mem_address    = addr_q;
   assign bus.mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven directed vectors, hand-written
// multi-cycle sequences and randomized traffic against a transaction model.
module tb_mem_port_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = 128;
   localparam int VW = 7 + AW + DW + BW;

   localparam logic [BW-1:0] BA = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [BW-1:0] BB = 128'hCAFEF00D_55AA33CC_0F1E2D3C_4B5A6978;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .WIDTH(DW), .BLOCK_WIDTH(BW)) bus ();

   mem_port_arbiter #(.ADDR_WIDTH(AW), .WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: one transaction in flight, then one response cycle.
   bit            m_active, m_resp, m_last, m_op;
   int            m_owner;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [BW-1:0] m_rdata;

   // Memory responder control
   bit auto_mem = 0;
   bit stray    = 0;
   int mem_lat  = 3;
   int mem_cnt  = 0;

   typedef struct {
      bit rst; bit r0r; bit r0w; logic [AW-1:0] a0; logic [DW-1:0] w0;
      bit r1r; bit r1w; logic [AW-1:0] a1; logic [DW-1:0] w1;
      bit rdy; logic [BW-1:0] rdin;
      logic [1:0] g; bit bsy; bit mr; bit mw; bit d0; bit d1;
      logic [AW-1:0] ea; logic [DW-1:0] ew; logic [BW-1:0] er;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] dut_vec();
      return {bus.grant, bus.busy, bus.mem_read, bus.mem_write, bus.req0_done,
              bus.req1_done, bus.mem_address, bus.mem_write_data, bus.rdata};
   endfunction

   function automatic logic [VW-1:0] model_vec();
      logic [1:0] g;
      logic       on;
      on = m_active || m_resp;
      g  = on ? ((m_owner == 0) ? 2'b01 : 2'b10) : 2'b00;
      return {g, on, m_active && !m_op, m_active && m_op, m_resp && (m_owner == 0),
              m_resp && (m_owner == 1), m_addr, m_wdata, m_rdata};
   endfunction

   function automatic logic [VW-1:0] exp_vec(input vec_t v);
      return {v.g, v.bsy, v.mr, v.mw, v.d0, v.d1, v.ea, v.ew, v.er};
   endfunction

   function automatic bit model_done(input int n);
      return m_resp && (m_owner == n);
   endfunction

   task automatic set_req(input int n, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] w);
      if (n == 0) begin
         bus.req0_read = rd; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = w;
      end else begin
         bus.req1_read = rd; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = w;
      end
   endtask

   // One clock: advance the model with the inputs present at the edge,
   // optionally compare, then let the memory responder choose mem_ready.
   task automatic step(input bit cmp);
      bit s_rst, s_r0r, s_r0w, s_r1r, s_r1w, s_rdy, p0, p1;
      logic [AW-1:0] s_a0, s_a1;
      logic [DW-1:0] s_w0, s_w1;
      logic [BW-1:0] s_rdin;
      s_rst = reset;
      s_r0r = bus.req0_read; s_r0w = bus.req0_write; s_a0 = bus.req0_addr; s_w0 = bus.req0_wdata;
      s_r1r = bus.req1_read; s_r1w = bus.req1_write; s_a1 = bus.req1_addr; s_w1 = bus.req1_wdata;
      s_rdy = bus.mem_ready; s_rdin = bus.mem_read_data;
      @(posedge clk);
      #1;
      if (s_rst) begin
         m_active = 0; m_resp = 0; m_last = 1; m_owner = 0; m_op = 0;
         m_addr = '0; m_wdata = '0; m_rdata = '0;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_active) begin
         if (s_rdy) begin
            m_rdata = s_rdin; m_active = 0; m_resp = 1;
         end
      end else begin
         p0 = s_r0r || s_r0w;
         p1 = s_r1r || s_r1w;
         if (p0 || p1) begin
            if (p0 && p1) m_owner = m_last ? 0 : 1;
            else          m_owner = p0 ? 0 : 1;
            m_active = 1;
            m_last   = (m_owner == 1);
            if (m_owner == 0) begin m_op = s_r0w; m_addr = s_a0; m_wdata = s_w0; end
            else              begin m_op = s_r1w; m_addr = s_a1; m_wdata = s_w1; end
         end
      end
      if (cmp) check("cycle_outputs", dut_vec(), model_vec());
      if (auto_mem) begin
         bus.mem_read_data = {$urandom, $urandom, $urandom, $urandom};
         if (m_active) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
               bus.mem_ready = 1'b1;
               mem_cnt = 0;
            end else begin
               bus.mem_ready = 1'b0;
            end
         end else begin
            mem_cnt = 0;
            bus.mem_ready = stray && ($urandom_range(0, 9) == 0);
         end
      end
   endtask

   task automatic quiet_reset();
      set_req(0, 0, 0, '0, '0);
      set_req(1, 0, 0, '0, '0);
      bus.mem_ready = 1'b0;
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   initial begin
      int order[$];
      int gaps[$];
      int idle_run;
      int cool0, cool1;
      logic [1:0] g;
      bit hold[2];

      reset = 1'b1;
      set_req(0, 0, 0, '0, '0);
      set_req(1, 0, 0, '0, '0);
      bus.mem_ready = 1'b0;
      bus.mem_read_data = '0;

      //            rst r0r r0w a0      w0            r1r r1w a1      w1            rdy rdin  g     bsy mr mw d0 d1 ea      ew            er
      tbl[0]  = '{1, 0, 0, 10'h000, 32'h0,        0, 0, 10'h000, 32'h0,        0, BA, 2'b00, 0, 0, 0, 0, 0, 10'h000, 32'h0,        '0};
      tbl[1]  = '{0, 1, 0, 10'h084, 32'h0,        0, 0, 10'h000, 32'h0,        0, BA, 2'b01, 1, 1, 0, 0, 0, 10'h084, 32'h0,        '0};
      tbl[2]  = '{0, 1, 0, 10'h084, 32'h0,        0, 0, 10'h000, 32'h0,        0, BA, 2'b01, 1, 1, 0, 0, 0, 10'h084, 32'h0,        '0};
      tbl[3]  = '{0, 1, 0, 10'h084, 32'h0,        0, 0, 10'h000, 32'h0,        0, BA, 2'b01, 1, 1, 0, 0, 0, 10'h084, 32'h0,        '0};
      tbl[4]  = '{0, 1, 0, 10'h084, 32'h0,        0, 0, 10'h000, 32'h0,        1, BA, 2'b01, 1, 0, 0, 1, 0, 10'h084, 32'h0,        BA};
      tbl[5]  = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 10'h000, 32'h0,        0, BA, 2'b00, 0, 0, 0, 0, 0, 10'h084, 32'h0,        BA};
      tbl[6]  = '{0, 0, 0, 10'h000, 32'h0,        0, 1, 10'h3FF, 32'hDEADBEEF, 0, BB, 2'b10, 1, 0, 1, 0, 0, 10'h3FF, 32'hDEADBEEF, BA};
      tbl[7]  = '{0, 0, 0, 10'h000, 32'h0,        0, 1, 10'h3FF, 32'hDEADBEEF, 0, BB, 2'b10, 1, 0, 1, 0, 0, 10'h3FF, 32'hDEADBEEF, BA};
      tbl[8]  = '{0, 0, 0, 10'h000, 32'h0,        0, 1, 10'h3FF, 32'hDEADBEEF, 1, BB, 2'b10, 1, 0, 0, 0, 1, 10'h3FF, 32'hDEADBEEF, BB};
      tbl[9]  = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 10'h000, 32'h0,        0, BB, 2'b00, 0, 0, 0, 0, 0, 10'h3FF, 32'hDEADBEEF, BB};
      tbl[10] = '{0, 1, 1, 10'h155, 32'h12345678, 0, 0, 10'h000, 32'h0,        0, BA, 2'b01, 1, 0, 1, 0, 0, 10'h155, 32'h12345678, BB};
      tbl[11] = '{0, 1, 1, 10'h155, 32'h12345678, 0, 0, 10'h000, 32'h0,        1, BA, 2'b01, 1, 0, 0, 1, 0, 10'h155, 32'h12345678, BA};
      tbl[12] = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 10'h000, 32'h0,        0, BA, 2'b00, 0, 0, 0, 0, 0, 10'h155, 32'h12345678, BA};
      tbl[13] = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 10'h000, 32'h0,        1, BB, 2'b00, 0, 0, 0, 0, 0, 10'h155, 32'h12345678, BA};

      // Directed vectors: single read, write, read+write, stray mem_ready
      for (int i = 0; i < 14; i++) begin
         reset = tbl[i].rst;
         set_req(0, tbl[i].r0r, tbl[i].r0w, tbl[i].a0, tbl[i].w0);
         set_req(1, tbl[i].r1r, tbl[i].r1w, tbl[i].a1, tbl[i].w1);
         bus.mem_ready = tbl[i].rdy;
         bus.mem_read_data = tbl[i].rdin;
         step(0);
         check($sformatf("vec%0d", i), dut_vec(), exp_vec(tbl[i]));
      end

      // Tie from reset: both requesters read continuously
      auto_mem = 1; stray = 0; mem_lat = 2;
      quiet_reset();
      set_req(0, 1, 0, 10'h011, '0);
      set_req(1, 1, 0, 10'h022, '0);
      idle_run = 0; cool0 = 0; cool1 = 0;
      for (int c = 0; c < 60 && order.size() < 4; c++) begin
         step(1);
         g = bus.grant;
         if (g == 2'b00) idle_run++;
         else if (!(m_active && mem_cnt == 1)) begin end
         if (g != 2'b00 && bus.busy && bus.mem_read && mem_cnt == 1) begin
            if (order.size() > 0) gaps.push_back(idle_run);
            order.push_back((g == 2'b01) ? 0 : 1);
            idle_run = 0;
         end
         if (cool0) begin bus.req0_read = 1'b1; cool0 = 0; end
         if (cool1) begin bus.req1_read = 1'b1; cool1 = 0; end
         if (model_done(0)) begin bus.req0_read = 1'b0; cool0 = 1; end
         if (model_done(1)) begin bus.req1_read = 1'b0; cool1 = 1; end
      end
      check("rr_count", VW'(order.size()), VW'(4));
      foreach (order[i]) check($sformatf("rr_order%0d", i), VW'(order[i]), VW'(i % 2));
      foreach (gaps[i]) check($sformatf("rr_gap%0d", i), VW'(gaps[i]), VW'(1));
      quiet_reset();

      // Owner changes its address while BUSY; latched address must hold
      mem_lat = 3;
      set_req(0, 1, 0, 10'h010, 32'h0000_00A5);
      step(1);
      check("hold_addr_t1", VW'(bus.mem_address), VW'(10'h010));
      bus.req0_addr = 10'h020;
      for (int c = 0; c < 8; c++) begin
         step(1);
         if (c < 2) check("hold_addr", VW'(bus.mem_address), VW'(10'h010));
         if (model_done(0)) set_req(0, 0, 0, '0, '0);
      end
      quiet_reset();

      // Reset while the strobe is high
      mem_lat = 5;
      set_req(1, 1, 0, 10'h0AA, '0);
      step(1);
      check("rst_strobe", VW'(bus.mem_read), VW'(1));
      reset = 1'b1;
      step(1);
      check("rst_clear", dut_vec(), '0);
      reset = 1'b0;
      bus.req0_read = 1'b1; bus.req0_addr = 10'h055;
      step(1);
      check("rst_first_tie", VW'(bus.grant), VW'(2'b01));
      quiet_reset();

      // Randomized traffic against the model
      stray = 1;
      hold[0] = 0; hold[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!m_active) mem_lat = $urandom_range(1, 4);
         reset = ($urandom_range(0, 299) == 0);
         step(1);
         for (int n = 0; n < 2; n++) begin
            if (hold[n]) begin
               if (model_done(n)) begin
                  set_req(n, 0, 0, '0, '0);
                  hold[n] = 0;
               end else if ($urandom_range(0, 7) == 0) begin
                  if (n == 0) begin bus.req0_addr = AW'($urandom); bus.req0_wdata = $urandom; end
                  else        begin bus.req1_addr = AW'($urandom); bus.req1_wdata = $urandom; end
               end
            end else if ($urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 2))
                  0:       set_req(n, 1, 0, AW'($urandom), $urandom);
                  1:       set_req(n, 0, 1, AW'($urandom), $urandom);
                  default: set_req(n, 1, 1, AW'($urandom), $urandom);
               endcase
               hold[n] = 1;
            end
         end
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
